hazard_scoreboard: RTL and testbench

Parametrised hazard-detection and forwarding-select unit for the in-order MIPS pipelines, generalising fixed EX/MEM forwarding and load-use bubbles to an arbitrary number of post-issue stages and per-instruction result latency. It sits between the ID stage and the issue point. It tracks in-flight destination registers in a shift register, one entry per pipeline stage. It tells ID whether to stall and which stage each source operand is forwarded from. It also supports selective squash of in-flight entries and keeps a saturating stall counter.

---
 rtl/hazard_scoreboard_if.sv | 37 +++
 rtl/hazard_scoreboard.sv | 111 +++++++++++
 tb/tb_hazard_scoreboard.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_scoreboard_if.sv
// Issue-side bundle between the ID stage and the hazard scoreboard.
// The ID stage drives the instruction fields and reads back stall, fire and forwarding selects.
interface hazard_scoreboard_if #(
    parameter int MAX_LAT = 4,
    parameter int AW      = 5
);
    localparam int SW = $clog2(MAX_LAT + 1);
    localparam int LW = $clog2(MAX_LAT + 1);

    logic               issue_valid;
    logic [AW-1:0]      issue_rs;
    logic [AW-1:0]      issue_rt;
    logic               issue_rs_used;
    logic               issue_rt_used;
    logic               issue_wr;
    logic [AW-1:0]      issue_rd;
    logic [LW-1:0]      issue_lat;
    logic               flush;
    logic [MAX_LAT-1:0] kill_mask;
    logic               stall;
    logic               issue_fire;
    logic [SW-1:0]      fwd_rs_sel;
    logic [SW-1:0]      fwd_rt_sel;
    logic [15:0]        stall_cnt;

    modport master (
        output issue_valid, issue_rs, issue_rt, issue_rs_used, issue_rt_used,
        output issue_wr, issue_rd, issue_lat, flush, kill_mask,
        input  stall, issue_fire, fwd_rs_sel, fwd_rt_sel, stall_cnt
    );

    modport slave (
        input  issue_valid, issue_rs, issue_rt, issue_rs_used, issue_rt_used,
        input  issue_wr, issue_rd, issue_lat, flush, kill_mask,
        output stall, issue_fire, fwd_rs_sel, fwd_rt_sel, stall_cnt
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Tracks in-flight destination registers, one entry per post-issue stage, and
// derives the ID stall and per-source forwarding stage from them.
module hazard_scoreboard #(
    parameter int MAX_LAT = 4,
    parameter int AW      = 5
) (
    input  logic          clk,
    input  logic          rst,
    hazard_scoreboard_if.slave bus
);
    localparam int SW = $clog2(MAX_LAT + 1);
    localparam int LW = $clog2(MAX_LAT + 1);

    logic [MAX_LAT:1] ent_valid;
    logic [AW-1:0]    ent_rd  [1:MAX_LAT];
    logic [LW-1:0]    ent_lat [1:MAX_LAT];

    logic [LW-1:0] lat_eff;
    logic          rs_hit;
    logic          rt_hit;
    logic [SW-1:0] rs_k;
    logic [SW-1:0] rt_k;
    logic [LW-1:0] rs_lat;
    logic [LW-1:0] rt_lat;
    logic          rs_live;
    logic          rt_live;
    logic          rs_haz;
    logic          rt_haz;
    logic          stall_int;
    logic          fire_int;

    // An entry killed while in the last stage retires regardless, so that bit has no effect.
    logic unused_kill_last;
    assign unused_kill_last = bus.kill_mask[MAX_LAT-1];

    always_comb begin
        lat_eff = bus.issue_lat;
        if (bus.issue_lat == '0) begin
            lat_eff = LW'(1);
        end else if (bus.issue_lat > LW'(MAX_LAT)) begin
            lat_eff = LW'(MAX_LAT);
        end
    end

    // Scanning oldest to youngest lets the youngest match overwrite older ones.
    always_comb begin
        rs_hit = 1'b0;
        rs_k   = '0;
        rs_lat = '0;
        rt_hit = 1'b0;
        rt_k   = '0;
        rt_lat = '0;
        for (int k = MAX_LAT; k >= 1; k--) begin
            if (ent_valid[k] && (ent_rd[k] == bus.issue_rs)) begin
                rs_hit = 1'b1;
                rs_k   = SW'(k);
                rs_lat = ent_lat[k];
            end
            if (ent_valid[k] && (ent_rd[k] == bus.issue_rt)) begin
                rt_hit = 1'b1;
                rt_k   = SW'(k);
                rt_lat = ent_lat[k];
            end
        end
    end

    always_comb begin
        rs_live   = rs_hit && bus.issue_rs_used && (bus.issue_rs != '0);
        rt_live   = rt_hit && bus.issue_rt_used && (bus.issue_rt != '0);
        rs_haz    = rs_live && (rs_k < rs_lat);
        rt_haz    = rt_live && (rt_k < rt_lat);
        stall_int = bus.issue_valid && !bus.flush && (rs_haz || rt_haz);
        fire_int  = bus.issue_valid && !bus.flush && !stall_int;
    end

    assign bus.stall      = stall_int;
    assign bus.issue_fire = fire_int;
    assign bus.fwd_rs_sel = rs_live ? rs_k : '0;
    assign bus.fwd_rt_sel = rt_live ? rt_k : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ent_valid <= '0;
            for (int k = 1; k <= MAX_LAT; k++) begin
                ent_rd[k]  <= '0;
                ent_lat[k] <= '0;
            end
        end else begin
            for (int k = MAX_LAT; k >= 2; k--) begin
                ent_valid[k] <= ent_valid[k-1] && !bus.kill_mask[k-2];
                ent_rd[k]    <= ent_rd[k-1];
                ent_lat[k]   <= ent_lat[k-1];
            end
            ent_valid[1] <= fire_int && bus.issue_wr && (bus.issue_rd != '0);
            ent_rd[1]    <= bus.issue_rd;
            ent_lat[1]   <= lat_eff;
        end
    end

    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
        end else if (stall_int && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign bus.stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench: the driver predicts from a list of in-flight instructions
// and queues expectations; a monitor compares them against the DUT each cycle.
module tb_hazard_scoreboard;
    localparam int MAX_LAT = 4;
    localparam int AW      = 5;

    logic clk;
    logic rst;

    hazard_scoreboard_if #(.MAX_LAT(MAX_LAT), .AW(AW)) bus ();

    hazard_scoreboard #(.MAX_LAT(MAX_LAT), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int fire_cyc;
        int rd;
        int lat;
        bit killed;
    } inst_t;

    typedef struct {
        bit stall;
        bit fire;
        bit rs_haz;
        bit rt_haz;
        int rs_sel;
        int rt_sel;
        int cnt;
    } exp_t;

    inst_t infl[$];
    exp_t  expq[$];
    int    cyc;
    int    m_cnt;
    int    raw_stalls;
    int    checks;
    int    passes;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Result-ready stage of the youngest live producer of s decides forwarding.
    function automatic void lookup(input int s, input bit used,
                                   output bit haz, output int sel);
        int best = 0;
        int blat = 0;
        foreach (infl[i]) begin
            int st = cyc - infl[i].fire_cyc;
            if (!infl[i].killed && st >= 1 && st <= MAX_LAT && infl[i].rd == s &&
                (best == 0 || st < best)) begin
                best = st;
                blat = infl[i].lat;
            end
        end
        haz = used && s != 0 && best != 0 && best < blat;
        sel = (used && s != 0) ? best : 0;
    endfunction

    task automatic drive(input bit v, input int rs, input int rt, input bit ru, input bit tu,
                         input bit wr, input int rd, input int lat, input bit fl,
                         input int km, input bit r, output bit fired);
        exp_t e;
        int   le;
        rst = r;
        if (!r) begin
            infl.delete();
            m_cnt = 0;
        end
        bus.issue_valid   = v;
        bus.issue_rs      = 5'(rs);
        bus.issue_rt      = 5'(rt);
        bus.issue_rs_used = ru;
        bus.issue_rt_used = tu;
        bus.issue_wr      = wr;
        bus.issue_rd      = 5'(rd);
        bus.issue_lat     = 3'(lat);
        bus.flush         = fl;
        bus.kill_mask     = 4'(km);
        lookup(rs, ru, e.rs_haz, e.rs_sel);
        lookup(rt, tu, e.rt_haz, e.rt_sel);
        e.stall = v && !fl && (e.rs_haz || e.rt_haz);
        e.fire  = v && !fl && !e.stall;
        e.cnt   = m_cnt;
        expq.push_back(e);
        fired = e.fire;
        le = (lat == 0) ? 1 : ((lat > MAX_LAT) ? MAX_LAT : lat);
        @(posedge clk);
        if (!rst) begin
            infl.delete();
            m_cnt = 0;
        end else begin
            foreach (infl[i]) begin
                int st = cyc - infl[i].fire_cyc;
                if (st >= 1 && st <= MAX_LAT && km[st-1]) infl[i].killed = 1'b1;
            end
            if (e.fire && wr && rd != 0) infl.push_back('{cyc, rd, le, 1'b0});
            if (e.stall) begin
                raw_stalls++;
                if (m_cnt < 65535) m_cnt++;
            end
        end
        cyc++;
        while (infl.size() > 0 && cyc - infl[0].fire_cyc > MAX_LAT) void'(infl.pop_front());
        #1;
    endtask

    task automatic idle(input int n);
        bit f;
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, f);
    endtask

    task automatic issue(input int rs, input int rt, input bit ru, input bit tu,
                         input bit wr, input int rd, input int lat);
        bit f;
        drive(1, rs, rt, ru, tu, wr, rd, lat, 0, 0, 1, f);
    endtask

    // Holds the instruction in ID until the model predicts it fires.
    task automatic issue_until_fire(input int rs, input int rt, input bit ru, input bit tu,
                                    input bit wr, input int rd, input int lat);
        bit f = 1'b0;
        int n = 0;
        while (!f && n < 20) begin
            drive(1, rs, rt, ru, tu, wr, rd, lat, 0, 0, 1, f);
            n++;
        end
        chk("fire_bound", int'(f), 1);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("stall", int'(bus.stall), int'(e.stall));
                chk("issue_fire", int'(bus.issue_fire), int'(e.fire));
                chk("stall_cnt", int'(bus.stall_cnt), e.cnt);
                if (!e.rs_haz) chk("fwd_rs_sel", int'(bus.fwd_rs_sel), e.rs_sel);
                if (!e.rt_haz) chk("fwd_rt_sel", int'(bus.fwd_rt_sel), e.rt_sel);
            end
        end
    end

    initial begin : watchdog
        #1500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "time limit");
    end

    initial begin : driver
        bit f;
        int n;
        cyc = 0; m_cnt = 0; raw_stalls = 0; checks = 0; passes = 0;
        rst = 1'b0;
        bus.issue_valid = 0; bus.issue_rs = '0; bus.issue_rt = '0;
        bus.issue_rs_used = 0; bus.issue_rt_used = 0; bus.issue_wr = 0;
        bus.issue_rd = '0; bus.issue_lat = '0; bus.flush = 0; bus.kill_mask = '0;
        repeat (3) @(posedge clk);
        #1;
        drive(1, 5, 0, 1, 0, 0, 0, 0, 0, 0, 0, f);
        idle(2);

        // ALU chain
        issue(0, 0, 0, 0, 1, 5, 1);
        issue(5, 0, 1, 0, 0, 0, 0);
        issue(0, 5, 0, 1, 0, 0, 0);
        idle(4);

        // load-use, lat 3 then lat 4
        issue(0, 0, 0, 0, 1, 8, 3);
        issue_until_fire(8, 0, 1, 0, 0, 0, 0);
        idle(4);
        issue(0, 0, 0, 0, 1, 8, 4);
        issue_until_fire(8, 0, 1, 0, 0, 0, 0);
        idle(4);

        // youngest match wins
        issue(0, 0, 0, 0, 1, 3, 1);
        issue(0, 0, 0, 0, 1, 3, 1);
        issue(3, 0, 1, 0, 0, 0, 0);
        idle(4);

        // r0 and unused sources
        issue(0, 0, 0, 0, 1, 0, 3);
        issue(0, 0, 1, 0, 0, 0, 0);
        issue(0, 0, 0, 0, 1, 8, 3);
        issue(0, 8, 0, 0, 0, 0, 0);
        issue(8, 0, 0, 0, 0, 0, 0);
        idle(4);

        // kill in stage 1 removes the hazard
        issue(0, 0, 0, 0, 1, 8, 3);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, f);
        issue(8, 0, 1, 0, 0, 0, 0);
        idle(4);

        // flush beats stall; kill in the stall cycle does not change that cycle's decision
        issue(0, 0, 0, 0, 1, 8, 3);
        drive(1, 8, 0, 1, 0, 0, 0, 0, 1, 0, 1, f);
        drive(1, 8, 0, 1, 0, 0, 0, 0, 0, 4'b0100, 1, f);
        drive(1, 8, 0, 1, 0, 0, 0, 0, 0, 0, 1, f);
        idle(4);

        // reset mid-operation with entries in flight
        issue(0, 0, 0, 0, 1, 9, 4);
        issue_until_fire(9, 0, 1, 0, 1, 5, 4);
        issue(0, 0, 0, 0, 1, 6, 4);
        issue(0, 0, 0, 0, 1, 7, 4);
        drive(1, 5, 6, 1, 1, 0, 0, 0, 0, 0, 0, f);
        drive(1, 7, 0, 1, 0, 0, 0, 0, 0, 0, 0, f);
        issue(5, 6, 1, 1, 0, 0, 0);
        idle(2);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                  $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 9) == 0,
                  ($urandom_range(0, 5) == 0) ? $urandom_range(0, 15) : 0,
                  $urandom_range(0, 99) != 0, f);
        end
        idle(5);

        // saturation: self-dependent lat-4 chain stalls three cycles in four
        n = 0;
        raw_stalls = 0;
        while (raw_stalls < 65540 && n < 90000) begin
            drive(1, 8, 0, 1, 0, 1, 8, 4, 0, 0, 1, f);
            n++;
        end
        chk("sat_stall_cycles", int'(raw_stalls >= 65540), 1);
        chk("stall_cnt_sat", int'(bus.stall_cnt), 32'hFFFF);
        idle(3);

        chk("queue_drain", expq.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
